// File: rtl/adc_if_pkg.sv
// rtl/adc_if_pkg.sv - shared constants and state encoding for the ADC serial link
package adc_if_pkg;

  localparam int DATA_W_DEF = 8;

  // Line levels shared with the receive path
  localparam logic CS_ACTIVE = 1'b0;
  localparam logic SCLK_IDLE = 1'b0;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_serial_tx_if.sv
// rtl/adc_serial_tx_if.sv - sample handshake and serial line bundle for adc_serial_tx
interface adc_serial_tx_if #(
  parameter int DATA_W = adc_if_pkg::DATA_W_DEF
) ();

  logic [DATA_W-1:0] din;
  logic              valid;
  logic              ready;
  logic              cs;
  logic              sclk;
  logic              sdo;
  logic              done;
  logic              busy;

  modport master (
    output din, valid,
    input  ready, cs, sclk, sdo, done, busy
  );

  modport slave (
    input  din, valid,
    output ready, cs, sclk, sdo, done, busy
  );

endinterface

// File: rtl/sclk_tick_gen.sv
// rtl/sclk_tick_gen.sv - clock-enable tick every DIV_HALF cycles with synchronous clear
module sclk_tick_gen
  import adc_if_pkg::*;
#(
  parameter int DIV_HALF = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int DIV_W = min1_clog2(DIV_HALF);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV_HALF - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_serial_tx.sv
// rtl/adc_serial_tx.sv - CS-framed serial transmitter for the joystick ADC link
module adc_serial_tx
  import adc_if_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DIV_HALF  = 2,
  parameter int GAP_CYC   = 2,
  parameter int LSB_FIRST = 1
) (
  input  logic           clk_in,
  input  logic           reset,
  adc_serial_tx_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int GAP_W = min1_clog2(GAP_CYC);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYC - 1);

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              cs_q, cs_d;
  logic              sclk_q, sclk_d;
  logic              sdo_q, sdo_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;

  logic              tick;
  logic              div_clr;
  logic              accept;
  logic              din_first;
  logic              shift_first;
  logic [DATA_W-1:0] din_rest;
  logic [DATA_W-1:0] shift_rest;

  assign accept  = (state_q == ST_IDLE) && ready_q && bus.valid;
  assign div_clr = !((state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD));

  // The first bit goes straight to sdo on accept; the shift register keeps the rest
  always_comb begin
    if (LSB_FIRST != 0) begin
      din_first   = bus.din[0];
      din_rest    = bus.din >> 1;
      shift_first = shift_q[0];
      shift_rest  = shift_q >> 1;
    end else begin
      din_first   = bus.din[DATA_W-1];
      din_rest    = bus.din << 1;
      shift_first = shift_q[DATA_W-1];
      shift_rest  = shift_q << 1;
    end
  end

  sclk_tick_gen #(
    .DIV_HALF (DIV_HALF)
  ) u_tick (
    .clk_i  (clk_in),
    .rst_ni (reset),
    .clr_i  (div_clr),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    sdo_d     = sdo_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    ready_d   = ready_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_SETUP;
          shift_d   = din_rest;
          sdo_d     = din_first;
          cs_d      = CS_ACTIVE;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_SHIFT;
          sclk_d  = ~SCLK_IDLE;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (sclk_q == SCLK_IDLE) begin
            sclk_d  = ~SCLK_IDLE;
            sdo_d   = shift_first;
            shift_d = shift_rest;
          end else begin
            sclk_d    = SCLK_IDLE;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
              state_d = ST_HOLD;
            end
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d   = ST_GAP;
          cs_d      = ~CS_ACTIVE;
          sdo_d     = 1'b0;
          done_d    = 1'b1;
          gap_cnt_d = '0;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == LAST_GAP) begin
          state_d   = ST_IDLE;
          ready_d   = 1'b1;
          busy_d    = 1'b0;
          bit_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        shift_d   = '0;
        bit_cnt_d = '0;
        gap_cnt_d = '0;
        cs_d      = ~CS_ACTIVE;
        sclk_d    = SCLK_IDLE;
        sdo_d     = 1'b0;
        busy_d    = 1'b0;
        ready_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      cs_q      <= ~CS_ACTIVE;
      sclk_q    <= SCLK_IDLE;
      sdo_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      sdo_q     <= sdo_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.cs    = cs_q;
  assign bus.sclk  = sclk_q;
  assign bus.sdo   = sdo_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;

endmodule
